// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
package mips_pkg;

  // Operation select driven from the EX stage.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } mdOp_e;

  // Sequencer states of the iterative unit.
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } mdState_e;

endpackage

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO pair.
//
// state   | meaning
// --------+--------------------------------------------------------------
// MD_IDLE | no op in flight; accepts start, MTHI/MTLO
// MD_RUN  | one shift-add / restoring-divide step per clock, WIDTH steps
// MD_FIX  | sign correction, HI/LO write, one-cycle done pulse
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mdState_e           state, stateNext;
  mdOp_e              opReg;
  // Upper half: partial product / remainder. Lower half: multiplier / quotient.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CNT_W-1:0]   count;
  logic               negMain;   // product sign (mul) or quotient sign (div)
  logic               negRem;    // dividend sign, carried by the remainder
  logic               divZero;

  logic               launch;
  logic               opSigned;
  logic               opIsDiv;
  logic               srcaNeg;
  logic               srcbNeg;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;

  logic               runDiv;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     remShift;
  logic [WIDTH-1:0]   remDiff;
  logic               qBit;
  logic [2*WIDTH-1:0] accStep;

  logic [2*WIDTH-1:0] prodFixed;
  logic [WIDTH-1:0]   quoFixed;
  logic [WIDTH-1:0]   remFixed;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  assign busy   = (state != MD_IDLE);
  // A coincident flush suppresses the launch.
  assign launch = (state == MD_IDLE) && start && !flush;

  // Decode the incoming op and take operand magnitudes for signed ops.
  always_comb begin
    opSigned = (op == MD_MULT) || (op == MD_DIV);
    opIsDiv  = op[1];
    srcaNeg  = opSigned && srca[WIDTH-1];
    srcbNeg  = opSigned && srcb[WIDTH-1];
    magA     = srcaNeg ? -srca : srca;
    magB     = srcbNeg ? -srcb : srcb;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else       state <= stateNext;
  end

  // Next-state logic; flush abandons any in-flight op, including at the FIX edge.
  always_comb begin
    stateNext = state;
    case (state)
      MD_IDLE: if (launch) stateNext = MD_RUN;
      MD_RUN: begin
        if (flush)                   stateNext = MD_IDLE;
        else if (count == LAST_STEP) stateNext = MD_FIX;
      end
      MD_FIX:  stateNext = MD_IDLE;
      default: stateNext = MD_IDLE;
    endcase
  end

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    runDiv   = (opReg == MD_DIV) || (opReg == MD_DIVU);
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    // Only used when remShift >= opnd, so the truncated difference is exact.
    remDiff  = remShift[WIDTH-1:0] - opnd;
    qBit     = (remShift >= {1'b0, opnd});
    if (runDiv) begin
      accStep = qBit ? {remDiff, acc[WIDTH-2:0], 1'b1}
                     : {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      accStep = {mulSum, acc[WIDTH-1:1]};
    end
  end

  // Datapath registers: load on launch, step while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      opReg   <= MD_MULT;
      acc     <= '0;
      opnd    <= '0;
      count   <= '0;
      negMain <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
    end else if (launch) begin
      opReg   <= mdOp_e'(op);
      count   <= '0;
      negMain <= srcaNeg ^ srcbNeg;
      negRem  <= srcaNeg;
      if (opIsDiv) begin
        acc     <= {{WIDTH{1'b0}}, magA};
        opnd    <= magB;
        divZero <= (srcb == '0);
      end else begin
        acc     <= {{WIDTH{1'b0}}, magB};
        opnd    <= magA;
        divZero <= 1'b0;
      end
    end else if (state == MD_RUN) begin
      count <= count + 1'b1;
      acc   <= accStep;
    end
  end

  // Sign correction. A zero divisor yields an all-ones quotient, and the
  // remainder path already reconstructs srca because the dividend sign is reapplied.
  always_comb begin
    prodFixed = negMain ? -acc : acc;
    remFixed  = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    quoFixed  = divZero ? '1 : (negMain ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    if (runDiv) begin
      resHi = remFixed;
      resLo = quoFixed;
    end else begin
      resHi = prodFixed[2*WIDTH-1:WIDTH];
      resLo = prodFixed[WIDTH-1:0];
    end
  end

  // HI/LO and done: op completion, or MTHI/MTLO when idle and not launching.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == MD_FIX && !flush) begin
        hi   <= resHi;
        lo   <= resLo;
        done <= 1'b1;
      end else if (state == MD_IDLE && !start) begin
        if (mthi) hi <= srca;
        if (mtlo) lo <= srca;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic        start32, flush32, mthi32, mtlo32, busy32, done32;
  logic [1:0]  op32;
  logic [31:0] srca32, srcb32, hi32, lo32;

  logic        start8, flush8, mthi8, mtlo8, busy8, done8;
  logic [1:0]  op8;
  logic [7:0]  srca8, srcb8, hi8, lo8;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } expEntry_t;

  expEntry_t sbQ[$];
  int        checks   = 0;
  int        failures = 0;
  logic      busyAtLaunch;

  // Free-running clock.
  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .srca(srca32), .srcb(srcb32),
    .flush(flush32), .mthi(mthi32), .mtlo(mtlo32), .busy(busy32), .done(done32),
    .hi(hi32), .lo(lo32)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .srca(srca8), .srcb(srcb8),
    .flush(flush8), .mthi(mthi8), .mtlo(mtlo8), .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} for a w-bit op, built from native integer arithmetic.
  function automatic logic [63:0] refModel(input int w, input logic [1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, hiV, loV;
    logic [63:0] ua, ub, prod;
    longint      sa, sb, q, r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ua   = {32'd0, a & mask};
    ub   = {32'd0, b & mask};
    sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    hiV  = '0;
    loV  = '0;
    case (op)
      2'b00: begin
        prod = sa * sb;
        hiV  = 32'(prod >> w) & mask;
        loV  = prod[31:0] & mask;
      end
      2'b01: begin
        prod = ua * ub;
        hiV  = 32'(prod >> w) & mask;
        loV  = prod[31:0] & mask;
      end
      2'b10: begin
        if (ub == 0) begin
          loV = mask;
          hiV = ua[31:0];
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          loV = 32'(q) & mask;
          hiV = 32'(r) & mask;
        end
      end
      default: begin
        if (ub == 0) begin
          loV = mask;
          hiV = ua[31:0];
        end else begin
          loV = 32'(ua / ub);
          hiV = 32'(ua % ub);
        end
      end
    endcase
    return {hiV, loV};
  endfunction

  function automatic logic [31:0] pickOperand(input int w);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = mask;
      3:       v = 32'd1 << (w - 1);
      4:       v = mask >> 1;
      5:       v = 32'($urandom_range(0, 15));
      default: v = $urandom & mask;
    endcase
    return v;
  endfunction

  // Drive a start at the current negedge; returns at the negedge after the start edge.
  task automatic startOp(input bit use8, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] expHi,
                         input logic [31:0] expLo, input string tag);
    if (use8) begin
      op8 = op; srca8 = a[7:0]; srcb8 = b[7:0]; start8 = 1'b1;
    end else begin
      op32 = op; srca32 = a; srcb32 = b; start32 = 1'b1;
    end
    if (push) sbQ.push_back('{tag: tag, hi: expHi, lo: expLo});
    @(negedge clk);
    if (use8) begin
      start8 = 1'b0; busyAtLaunch = busy8;
    end else begin
      start32 = 1'b0; busyAtLaunch = busy32;
    end
  endtask

  // Wait (bounded) for done; 'elapsed' edges after the start edge have already passed.
  task automatic waitDone(input bit use8, input int elapsed, input string tag);
    int        w = use8 ? 8 : 32;
    int        lat = 0;
    int        busyCnt;
    bit        gotDone = 1'b0;
    expEntry_t e;
    busyCnt = int'(busyAtLaunch) + elapsed;
    for (int k = elapsed + 1; k <= w + 6; k++) begin
      @(negedge clk);
      if ((use8 ? done8 : done32) === 1'b1) begin
        gotDone = 1'b1;
        lat     = k;
        break;
      end
      if ((use8 ? busy8 : busy32) === 1'b1) busyCnt++;
    end
    check({tag, "_latency"}, lat, w + 1);
    check({tag, "_busy_cycles"}, busyCnt, w + 1);
    check({tag, "_busy_at_done"}, use8 ? busy8 : busy32, 0);
    if (gotDone) begin
      check({tag, "_sb_nonempty"}, sbQ.size() != 0, 1);
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        check({e.tag, "_hi"}, use8 ? {24'd0, hi8} : hi32, e.hi);
        check({e.tag, "_lo"}, use8 ? {24'd0, lo8} : lo32, e.lo);
      end
    end else if (sbQ.size() != 0) begin
      void'(sbQ.pop_front());
    end
  endtask

  task automatic countDones(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done32 === 1'b1) seen++;
    end
  endtask

  initial begin
    int          seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] re;

    reset = 1'b1;
    start32 = 0; flush32 = 0; mthi32 = 0; mtlo32 = 0; op32 = 0; srca32 = 0; srcb32 = 0;
    start8  = 0; flush8  = 0; mthi8  = 0; mtlo8  = 0; op8  = 0; srca8  = 0; srcb8  = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_busy", busy32, 0);
    check("reset_done", done32, 0);
    check("reset_hi", hi32, 0);
    check("reset_lo", lo32, 0);
    check("reset_busy8", busy8, 0);
    check("reset_hilo8", {hi8, lo8}, 0);

    // Unsigned max multiply.
    startOp(0, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1, 32'h1, 32'hFFFF_FFFE, "multu_max_x2");
    waitDone(0, 0, "multu_max_x2");

    // Signed multiply, then a signed divide launched in its done cycle.
    @(negedge clk);
    startOp(0, MD_MULT, 32'hFFFF_FFFD, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
    waitDone(0, 0, "mult_m3x5");
    startOp(0, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    waitDone(0, 0, "div_m7_2");

    // Divide by zero and signed overflow, chained back to back.
    startOp(0, MD_DIVU, 32'd7, 32'd0, 1, 32'd7, 32'hFFFF_FFFF, "divu_7_0");
    waitDone(0, 0, "divu_7_0");
    startOp(0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, "div_min_m1");
    waitDone(0, 0, "div_min_m1");
    startOp(0, MD_DIV, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_m5_0");
    waitDone(0, 0, "div_m5_0");
    @(negedge clk);
    check("done_pulse_width", done32, 0);

    // MTHI then MTLO while idle.
    mthi32 = 1'b1; srca32 = 32'h1234;
    @(negedge clk);
    mthi32 = 1'b0; mtlo32 = 1'b1; srca32 = 32'h5678;
    @(negedge clk);
    mtlo32 = 1'b0;
    check("mthi_value", hi32, 32'h1234);
    check("mtlo_value", lo32, 32'h5678);

    // Flush at edge 10 of a running divide.
    startOp(0, MD_DIVU, 32'd100, 32'd7, 0, 0, 0, "flush_run");
    repeat (9) @(negedge clk);
    flush32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    check("flush_busy", busy32, 0);
    check("flush_done", done32, 0);
    countDones(40, seen);
    check("flush_no_done", seen, 0);
    check("flush_hilo", {hi32, lo32}, {32'h1234, 32'h5678});

    // Flush and start together in idle: no launch.
    op32 = MD_DIVU; srca32 = 32'd100; srcb32 = 32'd7; start32 = 1'b1; flush32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; flush32 = 1'b0;
    check("flush_start_no_launch", busy32, 0);

    // Start and MTHI together: start wins, the MTHI write is lost.
    op32 = MD_DIVU; srca32 = 32'd50; srcb32 = 32'd5; start32 = 1'b1; mthi32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; mthi32 = 1'b0;
    check("start_over_mthi_busy", busy32, 1);
    repeat (2) @(negedge clk);
    flush32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    check("mthi_dropped", hi32, 32'h1234);

    // MTHI and MTLO together write both; then MTLO alone.
    mthi32 = 1'b1; mtlo32 = 1'b1; srca32 = 32'hCAFE;
    @(negedge clk);
    mthi32 = 1'b0; srca32 = 32'hABCD;
    @(negedge clk);
    mtlo32 = 1'b0;
    check("mt_both_hi", hi32, 32'hCAFE);
    check("mtlo_alone_lo", lo32, 32'hABCD);

    // Flush coinciding with the FIX edge suppresses the write.
    startOp(0, MD_MULTU, 32'd5, 32'd6, 0, 0, 0, "flush_fix");
    repeat (32) @(negedge clk);
    check("fix_still_busy", busy32, 1);
    flush32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    check("fix_flush_done", done32, 0);
    check("fix_flush_busy", busy32, 0);
    check("fix_flush_hilo", {hi32, lo32}, {32'hCAFE, 32'hABCD});
    @(negedge clk);
    check("fix_flush_done_late", done32, 0);

    // Start while busy is ignored.
    startOp(0, MD_MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd12, "multu_3x4");
    repeat (4) @(negedge clk);
    start32 = 1'b1; srca32 = 32'd9; srcb32 = 32'd9;
    @(negedge clk);
    start32 = 1'b0;
    check("busy_start_ignored", busy32, 1);
    waitDone(0, 5, "multu_3x4");

    // Reset at edge 20 of a running op.
    @(negedge clk);
    startOp(0, MD_MULTU, 32'd9, 32'd9, 0, 0, 0, "reset_mid");
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", busy32, 0);
    check("midreset_done", done32, 0);
    check("midreset_hilo", {hi32, lo32}, 64'd0);
    countDones(40, seen);
    check("midreset_no_done", seen, 0);

    // Random ops against the reference model, WIDTH=8.
    for (int i = 0; i < 500; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pickOperand(8);
      rb  = pickOperand(8);
      re  = refModel(8, rop, ra, rb);
      startOp(1, rop, ra, rb, 1, re[63:32], re[31:0], "rnd8");
      waitDone(1, 0, "rnd8");
      @(negedge clk);
      check("rnd8_done_width", done8, 0);
    end

    // Random ops against the reference model, WIDTH=32.
    for (int i = 0; i < 500; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pickOperand(32);
      rb  = pickOperand(32);
      re  = refModel(32, rop, ra, rb);
      startOp(0, rop, ra, rb, 1, re[63:32], re[31:0], "rnd32");
      waitDone(0, 0, "rnd32");
      @(negedge clk);
      check("rnd32_done_width", done32, 0);
    end

    check("sb_drained", sbQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
